// File: rtl/booth_drv.sv
// Operand sequencer and product collector in front of an 8x8 sequential Booth multiplier.
// Optional running accumulator of products is enabled with `define BOOTH_DRV_ACC_EN.
module booth_drv #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MUL_LAT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_x,
    input  logic [7:0]  in_y,
    output logic [7:0]  mul_x,
    output logic [7:0]  mul_y,
    output logic        mul_load,
    input  logic [15:0] mul_z,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_z,
    output logic        busy
`ifdef BOOTH_DRV_ACC_EN
    ,
    input  logic        acc_clr,
    output logic [23:0] acc_sum
`endif
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0]  CNT_INIT = 8'(MUL_LAT - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  mul_x_q, mul_x_d;
    logic [7:0]  mul_y_q, mul_y_d;
    logic        mul_load_q, mul_load_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] out_z_q, out_z_d;

    logic [15:0] fifo_mem [DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        full, empty, push, pop, capture;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push    = in_valid && !full;
    assign pop     = (state_q == IDLE) && !empty;
    assign capture = (state_q == DONE) && (!out_valid_q || out_ready);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= {in_x, in_y};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Next-state and output logic for the sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mul_x_d     = mul_x_q;
        mul_y_d     = mul_y_q;
        mul_load_d  = 1'b0;
        out_valid_d = capture | (out_valid_q & ~out_ready);
        out_z_d     = capture ? mul_z : out_z_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    {mul_x_d, mul_y_d} = fifo_mem[rd_ptr_q[AW-1:0]];
                    mul_load_d         = 1'b1;
                    state_d            = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = CNT_INIT;
                state_d = RUN;
            end
            RUN: begin
                if (cnt_q == 8'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DONE: begin
                if (capture) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            mul_x_q     <= 8'd0;
            mul_y_q     <= 8'd0;
            mul_load_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_z_q     <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mul_x_q     <= mul_x_d;
            mul_y_q     <= mul_y_d;
            mul_load_q  <= mul_load_d;
            out_valid_q <= out_valid_d;
            out_z_q     <= out_z_d;
        end
    end

    assign in_ready  = !full;
    assign mul_x     = mul_x_q;
    assign mul_y     = mul_y_q;
    assign mul_load  = mul_load_q;
    assign out_valid = out_valid_q;
    assign out_z     = out_z_q;
    assign busy      = (state_q != IDLE) || !empty || out_valid_q;

`ifdef BOOTH_DRV_ACC_EN
    logic [23:0] acc_q, acc_d;
    logic [23:0] z_sext;

    // Clear on the capture cycle restarts the sum from the fresh product.
    assign z_sext = {{8{mul_z[15]}}, mul_z};

    always_comb begin
        acc_d = acc_q;
        if (capture) begin
            acc_d = acc_clr ? z_sext : acc_q + z_sext;
        end else if (acc_clr) begin
            acc_d = 24'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= 24'd0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_sum = acc_q;
`endif

endmodule
